isolator_sr_host: RTL
=====================

ISOLATOR_SR_HOST -- requirements
Module: isolator_sr_host

Interface
REQ-001 SHALL provide: clk  input  1  system clock; all logic on rising edge.
REQ-002 SHALL provide: reset  input  1  synchronous, active-low reset.
REQ-003 SHALL provide: enable  input  1  1 = run continuous frames; 0 = stop after the current frame.
REQ-004 SHALL provide: dmcs_par, amcs_par, clksel_par  input  4 each  per-slot values to send to the isolator.
REQ-005 SHALL provide: mclk  output  1  serial bit clock to the isolator, equal to clk/2 while shifting.
REQ-006 SHALL provide: srclk  output  1  parallel latch/load strobe to the isolator.
REQ-007 SHALL provide: dmcs, amcs, clksel  output  1 each  serial data to the isolator deserializers.
REQ-008 SHALL provide: dirchan, aovf  input  1 each  serial data from the isolator serializers.
REQ-009 SHALL provide: slot_dir, slot_chan, aovfl, aovfr  output  4 each  decoded per-slot status.
REQ-010 SHALL provide: rx_valid  output  1  one-cycle pulse when status outputs update.
REQ-011 SHALL provide: busy  output  1  high in any state other than IDLE.

Function
REQ-012 SHALL implement states IDLE, SHIFT and LATCH.
REQ-013 Transitions SHALL be: IDLE->SHIFT when enable=1; SHIFT->LATCH after bit 7 phase 1; LATCH->SHIFT after 2 cycles if enable=1, else LATCH->IDLE.
REQ-014 In IDLE, mclk, srclk, dmcs, amcs and clksel SHALL be 0; status outputs SHALL hold their values.
REQ-015 On each IDLE->SHIFT and LATCH->SHIFT edge, three 8-bit tx registers SHALL load {4'b0, x_par} as a snapshot; later changes to x_par SHALL NOT affect the frame in flight.
REQ-016 SHIFT SHALL be 8 bits x 2 clk cycles = 16 cycles; bit counter 0..7, phase 0/1.
REQ-017 Phase 0 SHALL drive mclk=0 and present tx bit [7-cnt] (MSB first) on dmcs, amcs and clksel; phase 1 SHALL drive mclk=1 with the same data.
REQ-018 On the clk edge at which mclk goes 0->1, dirchan and aovf SHALL be shifted into 8-bit rx registers, MSB first.
REQ-019 The first received bit SHALL be bit 7: dirchan word = {slot_chan[3:0], slot_dir[3:0]}; aovf word = {aovfr[3],aovfl[3],aovfr[2],aovfl[2],aovfr[1],aovfl[1],aovfr[0],aovfl[0]}.
REQ-020 LATCH SHALL last 2 cycles: cycle 1 srclk=1, mclk=0; cycle 2 srclk=0, mclk=0; serial outputs 0.
REQ-021 Frame length SHALL be exactly 18 clk cycles; back-to-back frames SHALL have no gap.
REQ-022 On entry to LATCH, if the primed flag is 1, the rx registers SHALL transfer to the status outputs and rx_valid SHALL pulse for 1 cycle, coincident with srclk=1.
REQ-023 The primed flag SHALL set at the first LATCH after IDLE; that first frame's rx data SHALL be discarded, because the isolator serializers were not yet loaded.
REQ-024 Latency SHALL be: a par snapshot reaches the isolator at the srclk rise 16 cycles after the snapshot edge.
REQ-025 Returning to IDLE SHALL clear the primed flag.
REQ-026 enable falling during SHIFT SHALL complete the frame including LATCH, then enter IDLE; enable rising during LATCH SHALL continue without a gap.
REQ-027 A status transfer SHALL NOT occur outside LATCH entry; rx_valid SHALL never pulse twice within one frame.

Reset
REQ-028 With reset=0 at a clk edge, the block SHALL enter IDLE, clear the bit counter, phase, tx/rx registers and primed flag, and drive mclk, srclk, serial outputs, status outputs, rx_valid and busy to 0.
REQ-029 Reset asserted mid-frame SHALL abort the frame with no srclk pulse and no rx_valid.
REQ-030 The first frame after reset release SHALL begin only when enable=1 is sampled in IDLE.

Verification
REQ-031 Reset release, enable=1, dmcs_par=4'b1010 -> 8 mclk rising edges, then srclk high 1 cycle at cycle 17; dmcs bit sequence 0,0,0,0,1,0,1,0; no rx_valid on this frame.
REQ-032 Loopback isolator model with slot_dir=4'b0010, slot_chan=4'b0010 and aovfl[1]=1 -> on the second LATCH, slot_dir=4'b0010, slot_chan=4'b0010, aovfl=4'b0010, aovfr=0, with rx_valid pulsing exactly once.
REQ-033 Change clksel_par from 4'h0 to 4'h2 at cycle 5 of a frame -> current frame still sends 0; next frame sends 8'h02; isolator clksel[1]=1 after that frame's srclk.
REQ-034 enable 1->0 at cycle 3 of a frame -> frame completes at 18 cycles, busy falls at cycle 19, outputs 0; re-enable -> the next frame's rx data is discarded again.
REQ-035 Reset low at cycle 9 of a frame -> next cycle state IDLE with all outputs 0; no srclk pulse.
REQ-036 Continuous run for 100 frames -> srclk period 18 cycles, mclk high width 1 cycle, and rx_valid count = 99.

Source files
------------

// File: rtl/isolator_sr_host_if.sv
// Serial link between the host and the isolator's shift registers.
// The host drives the clocks and outbound data; the isolator returns two serial streams.
interface isolator_sr_host_if;
  logic mclk;
  logic srclk;
  logic dmcs;
  logic amcs;
  logic clksel;
  logic dirchan;
  logic aovf;

  modport master (
    output mclk, srclk, dmcs, amcs, clksel,
    input  dirchan, aovf
  );

  modport slave (
    input  mclk, srclk, dmcs, amcs, clksel,
    output dirchan, aovf
  );
endinterface

// File: rtl/isolator_sr_host.sv
// Frame engine for the isolator link: 16 cycles shifting 8 bits at clk/2, then a 2-cycle latch.
// Status from the isolator is only trusted from the second frame of a run onward.
module isolator_sr_host (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [3:0]         dmcs_par,
  input  logic [3:0]         amcs_par,
  input  logic [3:0]         clksel_par,
  isolator_sr_host_if.master iso,
  output logic [3:0]         slot_dir,
  output logic [3:0]         slot_chan,
  output logic [3:0]         aovfl,
  output logic [3:0]         aovfr,
  output logic               rx_valid,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       phase_q, phase_d;
  logic       lcnt_q, lcnt_d;
  logic       primed_q, primed_d;
  logic [7:0] tx_dmcs_q, tx_dmcs_d;
  logic [7:0] tx_amcs_q, tx_amcs_d;
  logic [7:0] tx_clksel_q, tx_clksel_d;
  logic [7:0] rx_dir_q, rx_dir_d;
  logic [7:0] rx_aovf_q, rx_aovf_d;
  logic [3:0] slot_dir_q, slot_dir_d;
  logic [3:0] slot_chan_q, slot_chan_d;
  logic [3:0] aovfl_q, aovfl_d;
  logic [3:0] aovfr_q, aovfr_d;
  logic       rx_valid_q, rx_valid_d;
  logic       start_frame;
  logic       mclk_c, srclk_c, dmcs_c, amcs_c, clksel_c;

  // aovf word interleaves left/right flags per slot, left in the even bit.
  function automatic logic [3:0] even_bits(input logic [7:0] w);
    return {w[6], w[4], w[2], w[0]};
  endfunction

  function automatic logic [3:0] odd_bits(input logic [7:0] w);
    return {w[7], w[5], w[3], w[1]};
  endfunction

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    phase_d     = phase_q;
    lcnt_d      = lcnt_q;
    primed_d    = primed_q;
    tx_dmcs_d   = tx_dmcs_q;
    tx_amcs_d   = tx_amcs_q;
    tx_clksel_d = tx_clksel_q;
    rx_dir_d    = rx_dir_q;
    rx_aovf_d   = rx_aovf_q;
    slot_dir_d  = slot_dir_q;
    slot_chan_d = slot_chan_q;
    aovfl_d     = aovfl_q;
    aovfr_d     = aovfr_q;
    rx_valid_d  = 1'b0;
    start_frame = 1'b0;
    mclk_c      = 1'b0;
    srclk_c     = 1'b0;
    dmcs_c      = 1'b0;
    amcs_c      = 1'b0;
    clksel_c    = 1'b0;

    case (state_q)
      IDLE: begin
        if (enable) start_frame = 1'b1;
      end
      SHIFT: begin
        mclk_c   = phase_q;
        dmcs_c   = tx_dmcs_q[3'd7 - cnt_q];
        amcs_c   = tx_amcs_q[3'd7 - cnt_q];
        clksel_c = tx_clksel_q[3'd7 - cnt_q];
        if (!phase_q) begin
          // This edge is the mclk rise, where the isolator's data is valid.
          phase_d   = 1'b1;
          rx_dir_d  = {rx_dir_q[6:0], iso.dirchan};
          rx_aovf_d = {rx_aovf_q[6:0], iso.aovf};
        end else begin
          phase_d = 1'b0;
          if (cnt_q == 3'd7) begin
            state_d  = LATCH;
            lcnt_d   = 1'b0;
            primed_d = 1'b1;
            if (primed_q) begin
              slot_dir_d  = rx_dir_q[3:0];
              slot_chan_d = rx_dir_q[7:4];
              aovfl_d     = even_bits(rx_aovf_q);
              aovfr_d     = odd_bits(rx_aovf_q);
              rx_valid_d  = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      LATCH: begin
        srclk_c = ~lcnt_q;
        if (!lcnt_q) begin
          lcnt_d = 1'b1;
        end else if (enable) begin
          start_frame = 1'b1;
        end else begin
          state_d  = IDLE;
          primed_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (start_frame) begin
      state_d     = SHIFT;
      cnt_d       = 3'd0;
      phase_d     = 1'b0;
      tx_dmcs_d   = {4'b0, dmcs_par};
      tx_amcs_d   = {4'b0, amcs_par};
      tx_clksel_d = {4'b0, clksel_par};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      phase_q     <= 1'b0;
      lcnt_q      <= 1'b0;
      primed_q    <= 1'b0;
      tx_dmcs_q   <= 8'd0;
      tx_amcs_q   <= 8'd0;
      tx_clksel_q <= 8'd0;
      rx_dir_q    <= 8'd0;
      rx_aovf_q   <= 8'd0;
      slot_dir_q  <= 4'd0;
      slot_chan_q <= 4'd0;
      aovfl_q     <= 4'd0;
      aovfr_q     <= 4'd0;
      rx_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      phase_q     <= phase_d;
      lcnt_q      <= lcnt_d;
      primed_q    <= primed_d;
      tx_dmcs_q   <= tx_dmcs_d;
      tx_amcs_q   <= tx_amcs_d;
      tx_clksel_q <= tx_clksel_d;
      rx_dir_q    <= rx_dir_d;
      rx_aovf_q   <= rx_aovf_d;
      slot_dir_q  <= slot_dir_d;
      slot_chan_q <= slot_chan_d;
      aovfl_q     <= aovfl_d;
      aovfr_q     <= aovfr_d;
      rx_valid_q  <= rx_valid_d;
    end
  end

  assign iso.mclk   = mclk_c;
  assign iso.srclk  = srclk_c;
  assign iso.dmcs   = dmcs_c;
  assign iso.amcs   = amcs_c;
  assign iso.clksel = clksel_c;
  assign slot_dir   = slot_dir_q;
  assign slot_chan  = slot_chan_q;
  assign aovfl      = aovfl_q;
  assign aovfr      = aovfr_q;
  assign rx_valid   = rx_valid_q;
  assign busy       = (state_q != IDLE);

endmodule
